// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and defaults for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  localparam int DATA_W = 16;
  localparam int REQ_ADDR_W = 16;
  localparam int ADDR_W_DEF = 8;
  localparam int WAIT_CYC_DEF = 2;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with synchronous write, combinational read and asynchronous clear
module dmem_array import dmem_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_mem <= '{default: '0};
    else if (i_we) r_mem[i_addr] <= i_wdata;
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the MEM stage.
// Define DMEM_WAIT_EN to insert WAIT_CYC wait cycles before each response.
module dmem_responder import dmem_pkg::*; #(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int WAIT_CYC = WAIT_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [REQ_ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);
  if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait_cyc
    $error("WAIT_CYC must be in 1..15");
  end
  state_t r_state, w_next;
  logic r_live, w_accept, w_wait_done, w_enter, w_err, w_we;
  logic w_c_write;
  logic [REQ_ADDR_W-1:0] w_c_addr;
  logic [DATA_W-1:0] w_c_wdata, w_rdata, r_rdata;
  logic r_err;
`ifdef DMEM_WAIT_EN
  localparam state_t S_ACC = S_WAIT;
  logic [3:0] r_cnt;
  logic r_write;
  logic [REQ_ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_write <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_cnt <= 4'(WAIT_CYC - 1);
      r_write <= req_write;
      r_addr <= req_addr;
      r_wdata <= req_wdata;
    end else if (r_state == S_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
  assign w_wait_done = r_state == S_WAIT && r_cnt == 4'd0;
  assign w_c_write = r_write;
  assign w_c_addr = r_addr;
  assign w_c_wdata = r_wdata;
`else
  // Without wait cycles the commit happens on the accepting edge, so it uses the live request.
  localparam state_t S_ACC = S_RESP;
  assign w_wait_done = 1'b0;
  assign w_c_write = req_write;
  assign w_c_addr = req_addr;
  assign w_c_wdata = req_wdata;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_live <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live <= 1'b1;
    end
  always_comb begin
    req_ready = r_live && r_state == S_IDLE;
    rsp_valid = r_state == S_RESP;
    w_accept = req_valid && req_ready;
    w_next = w_accept ? S_ACC :
             w_wait_done ? S_RESP :
             (rsp_valid && rsp_ready) ? S_IDLE : r_state;
    w_enter = w_next == S_RESP && r_state != S_RESP;
  end
  assign w_err = w_c_addr[0] || |w_c_addr[REQ_ADDR_W-1:ADDR_W+1];
  assign w_we = w_enter && w_c_write && !w_err;
  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_we),
    .i_addr (w_c_addr[ADDR_W:1]),
    .i_wdata(w_c_wdata),
    .o_rdata(w_rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rdata <= '0;
      r_err <= 1'b0;
    end else if (w_enter) begin
      r_rdata <= (w_c_write || w_err) ? '0 : w_rdata;
      r_err <= w_err;
    end
  assign rsp_rdata = r_rdata;
  assign rsp_err = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed stimulus with a transaction-level reference model compared every cycle
module tb_dmem_responder;
  localparam int ADDR_W = 8;
  localparam int WAIT_CYC = 2;
`ifdef DMEM_WAIT_EN
  localparam int LAT = WAIT_CYC + 1;
`else
  localparam int LAT = 1;
`endif
  logic clk = 0, rst_n = 0, req_valid = 0, req_write = 0, rsp_ready = 0;
  logic [15:0] req_addr = 0, req_wdata = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  int n_chk = 0, n_fail = 0;

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding request, response LAT cycles after the accepting cycle.
  logic m_live = 0, m_busy = 0, m_err = 0, q_w = 0;
  int m_age = 0;
  logic [15:0] m_rdata = 0, q_a = 0, q_d = 0;
  logic [15:0] m_mem [256];

  function automatic logic f_err(input logic [15:0] a);
    return a[0] || (a >> (ADDR_W + 1)) != 0;
  endfunction

  task resolve(input logic w, input logic [15:0] a, input logic [15:0] d);
    if (w && !f_err(a)) m_mem[(a >> 1) % 256] <= d;
    m_rdata <= (!w && !f_err(a)) ? m_mem[(a >> 1) % 256] : 16'h0;
    m_err <= f_err(a);
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_live <= 0;
      m_busy <= 0;
      m_age <= 0;
      m_rdata <= 0;
      m_err <= 0;
      for (int i = 0; i < 256; i++) m_mem[i] <= 0;
    end else begin
      m_live <= 1;
      if (m_busy) begin
        if (m_age == LAT) begin
          if (rsp_ready) m_busy <= 0;
        end else begin
          m_age <= m_age + 1;
          if (m_age + 1 == LAT) resolve(q_w, q_a, q_d);
        end
      end else if (req_valid && m_live) begin
        m_busy <= 1;
        m_age <= 1;
        q_w <= req_write;
        q_a <= req_addr;
        q_d <= req_wdata;
        if (LAT == 1) resolve(req_write, req_addr, req_wdata);
      end
    end

  always @(negedge clk) begin
    chk("m_req_ready", req_ready, m_live && !m_busy);
    chk("m_rsp_valid", rsp_valid, m_busy && m_age == LAT);
    if (!rst_n || (m_busy && m_age == LAT)) begin
      chk("m_rsp_rdata", rsp_rdata, m_rdata);
      chk("m_rsp_err", rsp_err, m_err);
    end
  end

  task automatic rst_cycle();
    req_valid = 0;
    rst_n = 0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    #1 chk("ready_before_edge", req_ready, 0);
    @(posedge clk);
    #2 chk("ready_after_edge", req_ready, 1);
  endtask

  task automatic xact(input logic w, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] er, input logic ee, input int hold);
    int n;
    @(posedge clk);
    #2;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; rsp_ready = 0;
    chk("x_ready_idle", req_ready, 1);
    @(posedge clk);
    #2 req_valid = 0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #2 n++;
    end
    chk("x_latency", n, LAT);
    chk("x_rdata", rsp_rdata, er);
    chk("x_err", rsp_err, ee);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #2 req_valid = ~req_valid;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, er);
      chk("hold_err", rsp_err, ee);
      chk("hold_ready", req_ready, 0);
    end
    req_valid = 0;
    rsp_ready = 1;
    @(posedge clk);
    #2 rsp_ready = 0;
    chk("x_done_valid", rsp_valid, 0);
    chk("x_done_ready", req_ready, 1);
  endtask

  task automatic b2b(input logic w);
    int cyc, last, nacc, nrsp;
    logic rdy;
    cyc = 0; last = 0; nacc = 0; nrsp = 0;
    @(posedge clk);
    #2;
    rsp_ready = 1; req_valid = 1; req_write = w;
    req_addr = 16'h0040; req_wdata = 16'h1000;
    while (nacc < 8 && cyc < 200) begin
      @(negedge clk);
      rdy = req_ready;
      if (rsp_valid) nrsp++;
      @(posedge clk);
      #2 cyc++;
      if (rdy) begin
        if (nacc > 0) chk("b2b_interval", cyc - last, LAT + 1);
        last = cyc;
        nacc++;
        req_addr = 16'(16'h0040 + 2 * nacc);
        req_wdata = 16'(16'h1000 + nacc);
        if (nacc == 8) req_valid = 0;
      end
    end
    repeat (LAT + 3) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    chk("b2b_accepts", nacc, 8);
    chk("b2b_responses", nrsp, 8);
    @(posedge clk);
    #2 rsp_ready = 0;
  endtask

  initial begin
    @(posedge clk);
    #2 rst_cycle();
    xact(1, 16'h0004, 16'hBEEF, 16'h0000, 0, 0);
    xact(0, 16'h0004, 16'h0000, 16'hBEEF, 0, 0);
    xact(1, 16'h0002, 16'h5A5A, 16'h0000, 0, 0);
    xact(0, 16'h0003, 16'h0000, 16'h0000, 1, 0);
    xact(1, 16'h0003, 16'hFFFF, 16'h0000, 1, 0);
    xact(0, 16'h0002, 16'h0000, 16'h5A5A, 0, 0);
    xact(0, 16'h0200, 16'h0000, 16'h0000, 1, 0);
    xact(1, 16'h01FE, 16'h1234, 16'h0000, 0, 0);
    xact(0, 16'h01FE, 16'h0000, 16'h1234, 0, 0);
    xact(0, 16'h0004, 16'h0000, 16'hBEEF, 0, 5);
    @(posedge clk);
    #2;
    req_valid = 1; req_write = 1; req_addr = 16'h0010; req_wdata = 16'hAAAA;
    @(posedge clk);
    #2 rst_cycle();
    xact(0, 16'h0010, 16'h0000, 16'h0000, 0, 0);
    xact(0, 16'h0004, 16'h0000, 16'h0000, 0, 0);
    b2b(1);
    b2b(0);
    xact(0, 16'h004E, 16'h0000, 16'h1007, 0, 0);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, word-index width; 2^ADDR_W words of 16 bits.
REQ-002 Parameter WAIT_CYC, default 2, wait cycles inserted before each response when DMEM_WAIT_EN is defined; legal range 1..15.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  in  1  pipeline MEM stage presents a request.
REQ-006 req_ready  out  1  responder can accept a request.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  16  byte address from the pipeline ALU result.
REQ-009 req_wdata  in  16  store data.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  pipeline consumes the response.
REQ-012 rsp_rdata  out  16  load data; 0 for stores and errors.
REQ-013 rsp_err  out  1  request was misaligned or out of range.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-015 In IDLE: req_ready=1 and rsp_valid=0; req_valid=1 accepts the request, latches write/addr/wdata, and moves to WAIT (macro defined) or RESP (macro undefined).
REQ-016 In WAIT: req_ready=0; a down-counter loaded with WAIT_CYC-1 at acceptance decrements each cycle; at 0 the FSM moves to RESP.
REQ-017 On the edge entering RESP: a valid store writes the word, a valid load captures the word into rsp_rdata, and rsp_err is registered.
REQ-018 In RESP: rsp_valid=1 and req_ready=0; rsp_rdata and rsp_err hold stable until rsp_ready=1, then the FSM returns to IDLE.
REQ-019 The responder SHALL hold at most one outstanding request; a request arriving in WAIT or RESP is ignored because req_ready=0.
REQ-020 Word index is req_addr[ADDR_W:1]; req_addr[0]=1 or any nonzero bit in req_addr[15:ADDR_W+1] is an error.
REQ-021 An erroring store SHALL NOT modify memory; an erroring load SHALL return rsp_rdata=0.
REQ-022 Load latency from acceptance to rsp_valid is exactly 1 cycle without the macro and WAIT_CYC+1 cycles with it.
REQ-023 A store immediately followed by a load to the same address SHALL return the new data.

Reset
REQ-024 While rst_n=0, the FSM is in IDLE, the counter is 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0, and all memory words are 0.
REQ-025 A reset asserted mid-transaction SHALL abandon the transaction; a store not yet committed SHALL NOT be written.
REQ-026 req_ready SHALL rise on the first clock edge after rst_n deasserts.

Configuration
REQ-027 Macro DMEM_WAIT_EN: defined -> the WAIT state and counter exist with WAIT_CYC wait cycles; undefined -> WAIT and the counter are not built, and IDLE goes directly to RESP.

Structure
REQ-028 Package dmem_pkg SHALL hold the FSM state enum, the 16-bit data-width constant, and the ADDR_W and WAIT_CYC defaults.
REQ-029 Storage SHALL be the sub-module dmem_array: synchronous write, combinational read, asynchronous clear; the FSM, counter and error check stay in dmem_responder.

Verification
REQ-030 Store addr 0x0004, data 0xBEEF, then load 0x0004 -> rsp_rdata=0xBEEF, rsp_err=0; with the macro, rsp_valid rises 3 cycles after each acceptance (WAIT_CYC=2).
REQ-031 Load 0x0003 -> rsp_err=1, rsp_rdata=0; store 0x0003 -> rsp_err=1, and a following load of 0x0002 still returns its prior value.
REQ-032 Load 0x0200 with ADDR_W=8 -> rsp_err=1; store 0x01FE, data 0x1234, then load 0x01FE -> 0x1234 (top word).
REQ-033 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stay stable, and req_ready stays 0 while req_valid is pulsed.
REQ-034 Assert rst_n=0 during WAIT of a store 0x0010, data 0xAAAA -> outputs reach their reset values, and a later load 0x0010 returns 0.
REQ-035 Issue back-to-back requests with rsp_ready tied to 1 -> accepts occur every 2 cycles without the macro and every WAIT_CYC+2 cycles with it, with no lost or duplicated responses.
